// File: rtl/fu_vector_sequencer.sv
`timescale 1ns/1ps
// BIST sequencer for the 8-bit functional unit. It fetches an operand pair and an
// instruction/expected-result pair for each vector, drives the FU and counts mismatches.
module fu_vector_sequencer #(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 3,
    parameter int ADDR_W  = 10,
    parameter int NUM_VEC = 124,
    parameter int SETTLE  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [ADDR_W-1:0]   pat_addr,
    input  logic [DATA_W-1:0]   pat_data,
    output logic [ADDR_W-2:0]   gold_addr,
    input  logic [DATA_W-1:0]   gold_data,
    input  logic [INSTR_W-1:0]  gold_instr,
    output logic [DATA_W-1:0]   fu_a,
    output logic [DATA_W-1:0]   fu_b,
    output logic [INSTR_W-1:0]  fu_instr,
    input  logic [DATA_W-1:0]   fu_f,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         error_count,
    output logic                err_pulse,
    output logic [ADDR_W-2:0]   err_index,
    output logic [DATA_W-1:0]   err_got,
    output logic [DATA_W-1:0]   err_exp
);

    localparam int IDX_W = ADDR_W - 1;
    localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_APPLY, S_CHECK, S_DONE
    } state_t;

    state_t               r_state, w_next;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_W-1:0]    r_a_hold, r_exp;
    logic [INSTR_W-1:0]   r_instr;
    logic [CNT_W-1:0]     r_cnt;
    logic [DATA_W-1:0]    r_fu_a, r_fu_b;
    logic [INSTR_W-1:0]   r_fu_instr;
    logic                 r_done, r_pass, r_err_pulse;
    logic [15:0]          r_err_cnt;
    logic [IDX_W-1:0]     r_err_index;
    logic [DATA_W-1:0]    r_err_got, r_err_exp;
    logic                 w_odd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_RD_A;
            S_RD_A:         w_next = S_RD_B;
            S_RD_B:         w_next = S_CAP_B;
            S_CAP_B:        w_next = S_APPLY;
            S_APPLY:        if (r_cnt == CNT_W'(1)) w_next = S_CHECK;
            S_CHECK:        w_next = (r_idx == LAST_IDX) ? S_DONE : S_RD_A;
            default:        w_next = S_IDLE;
        endcase
    end

    // Odd (B) address is held from RD_B through CHECK so the address only steps forward.
    always_comb begin
        busy  = 1'b1;
        w_odd = 1'b1;
        case (r_state)
            S_IDLE, S_DONE: begin busy = 1'b0; w_odd = 1'b0; end
            S_RD_A:         w_odd = 1'b0;
            default:        ;
        endcase
        pat_addr  = {r_idx, w_odd};
        gold_addr = r_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_a_hold    <= '0;
            r_exp       <= '0;
            r_instr     <= '0;
            r_cnt       <= '0;
            r_fu_a      <= '0;
            r_fu_b      <= '0;
            r_fu_instr  <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
            r_err_index <= '0;
            r_err_got   <= '0;
            r_err_exp   <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_idx       <= '0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_cnt   <= '0;
                        r_err_index <= '0;
                        r_err_got   <= '0;
                        r_err_exp   <= '0;
                    end else if (r_state == S_DONE) begin
                        r_done <= 1'b1;
                        r_pass <= (r_err_cnt == 16'd0);
                    end
                end
                S_RD_B: begin
                    r_a_hold <= pat_data;
                    r_exp    <= gold_data;
                    r_instr  <= gold_instr;
                end
                S_CAP_B: begin
                    r_fu_a     <= r_a_hold;
                    r_fu_b     <= pat_data;
                    r_fu_instr <= r_instr;
                    r_cnt      <= SETTLE_LD;
                end
                S_APPLY: r_cnt <= r_cnt - CNT_W'(1);
                S_CHECK: begin
                    // Equality drives the match branch so an unknown fu_f lands in the mismatch branch.
                    if (fu_f == r_exp) begin
                        r_err_pulse <= 1'b0;
                    end else begin
                        r_err_pulse <= 1'b1;
                        r_err_index <= r_idx;
                        r_err_got   <= fu_f;
                        r_err_exp   <= r_exp;
                        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                    end
                    if (r_idx != LAST_IDX) r_idx <= r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign fu_a        = r_fu_a;
    assign fu_b        = r_fu_b;
    assign fu_instr    = r_fu_instr;
    assign done        = r_done;
    assign pass        = r_pass;
    assign error_count = r_err_cnt;
    assign err_pulse   = r_err_pulse;
    assign err_index   = r_err_index;
    assign err_got     = r_err_got;
    assign err_exp     = r_err_exp;

endmodule

// File: tb/tb_fu_vector_sequencer.sv
`timescale 1ns/1ps
// Bench for fu_vector_sequencer: memory and FU models, a scoreboard of expected
// mismatch reports, and directed plus randomized runs.
module tb_fu_vector_sequencer;

    localparam int DATA_W  = 8;
    localparam int INSTR_W = 3;
    localparam int ADDR_W  = 10;
    localparam int N       = 4;
    localparam int S       = 2;
    localparam int LAT     = 1 + (4 + S) * N;

    logic                clk, rst_n, start;
    logic [ADDR_W-1:0]   pat_addr;
    logic [DATA_W-1:0]   pat_data;
    logic [ADDR_W-2:0]   gold_addr;
    logic [DATA_W-1:0]   gold_data;
    logic [INSTR_W-1:0]  gold_instr;
    logic [DATA_W-1:0]   fu_a, fu_b, fu_f;
    logic [INSTR_W-1:0]  fu_instr;
    logic                busy, done, pass, err_pulse;
    logic [15:0]         error_count;
    logic [ADDR_W-2:0]   err_index;
    logic [DATA_W-1:0]   err_got, err_exp;

    logic [DATA_W-1:0]   pat_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0]   gold_d  [0:(1<<(ADDR_W-1))-1];
    logic [INSTR_W-1:0]  gold_i  [0:(1<<(ADDR_W-1))-1];

    typedef struct {
        int          idx;
        logic [7:0]  got;
        logic [7:0]  exp;
        logic [15:0] cnt;
    } err_t;
    err_t sb_q[$];

    int checks = 0;
    int errors = 0;

    fu_vector_sequencer #(
        .DATA_W(DATA_W), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .NUM_VEC(N), .SETTLE(S)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pat_addr(pat_addr), .pat_data(pat_data),
        .gold_addr(gold_addr), .gold_data(gold_data), .gold_instr(gold_instr),
        .fu_a(fu_a), .fu_b(fu_b), .fu_instr(fu_instr), .fu_f(fu_f),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
        .err_pulse(err_pulse), .err_index(err_index), .err_got(err_got), .err_exp(err_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] fu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] ins);
        case (ins)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return a << 1;
            default: return b;
        endcase
    endfunction

    assign fu_f = fu_model(fu_a, fu_b, fu_instr);

    // Synchronous-read memories: data follows the address by one cycle.
    always @(posedge clk) begin
        pat_data   <= pat_mem[pat_addr];
        gold_data  <= gold_d[gold_addr];
        gold_instr <= gold_i[gold_addr];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        err_t e;
        if (rst_n && err_pulse) begin
            if (sb_q.size() == 0) begin
                check("unexpected_err_pulse", 32'(err_index), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("err_index", 32'(err_index), 32'(e.idx));
                check("err_got", 32'(err_got), 32'(e.got));
                check("err_exp", 32'(err_exp), 32'(e.exp));
                check("err_count_at_pulse", 32'(error_count), 32'(e.cnt));
            end
        end
    end

    function automatic logic [7:0] good_f(input int v);
        return fu_model(pat_mem[2*v], pat_mem[2*v+1], gold_i[v]);
    endfunction

    task automatic do_run(input bit sat, input bit extra_start, input bit rst_mid);
        logic [15:0]       cnt;
        logic [7:0]        f;
        logic [ADDR_W-1:0] last_pa;
        int                k, pa_n;
        bit                pa_ok;
        cnt = sat ? 16'hFFFE : 16'h0;
        sb_q.delete();
        for (int v = 0; v < N; v++) begin
            f = good_f(v);
            if (f != gold_d[v]) begin
                if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
                sb_q.push_back('{v, f, gold_d[v], cnt});
            end
        end
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        if (sat) begin
            force u_dut.r_err_cnt = 16'hFFFE;
            #1 release u_dut.r_err_cnt;
        end
        k = 0;
        last_pa = pat_addr;
        pa_ok = (pat_addr == '0);
        pa_n = 1;
        while (!done && k < LAT + 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (extra_start && k == 4) start = 1'b1;
            if (extra_start && k == 5) start = 1'b0;
            if (busy && pat_addr != last_pa) begin
                pa_ok = pa_ok && (pat_addr == last_pa + 1'b1);
                last_pa = pat_addr;
                pa_n++;
            end
            if (rst_mid && k == 3 + S) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_fu_a", 32'(fu_a), 32'd0);
                check("rst_fu_b", 32'(fu_b), 32'd0);
                check("rst_error_count", 32'(error_count), 32'd0);
                check("rst_pat_addr", 32'(pat_addr), 32'd0);
                @(negedge clk);
                sb_q.delete();
                rst_n = 1'b1;
                return;
            end
        end
        check("done_latency", 32'(k), 32'(LAT));
        check("pass", 32'(pass), 32'(cnt == 16'h0));
        check("error_count", 32'(error_count), 32'(cnt));
        check("busy_in_done", 32'(busy), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("pat_addr_seq", pa_ok ? 32'(pa_n) : 32'hFFFF_FFFF, 32'(2 * N));
        check("fu_a_last", 32'(fu_a), 32'(pat_mem[2*N-2]));
        check("fu_b_last", 32'(fu_b), 32'(pat_mem[2*N-1]));
        check("fu_instr_last", 32'(fu_instr), 32'(gold_i[N-1]));
    endtask

    task automatic randomize_vectors(input int bad_pct);
        for (int v = 0; v < N; v++) begin
            pat_mem[2*v]   = 8'($urandom);
            pat_mem[2*v+1] = 8'($urandom);
            gold_i[v]      = 3'($urandom);
            gold_d[v]      = good_f(v);
            if (int'($urandom_range(99, 0)) < bad_pct)
                gold_d[v] = gold_d[v] ^ 8'($urandom_range(255, 1));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) pat_mem[i] = '0;
        for (int i = 0; i < (1 << (ADDR_W - 1)); i++) begin
            gold_d[i] = '0;
            gold_i[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pass", 32'(pass), 32'd0);
        check("reset_error_count", 32'(error_count), 32'd0);
        check("reset_err_pulse", 32'(err_pulse), 32'd0);
        check("reset_gold_addr", 32'(gold_addr), 32'd0);
        rst_n = 1'b1;

        // Two known vectors followed by random correct ones.
        randomize_vectors(0);
        pat_mem[0] = 8'h12; pat_mem[1] = 8'h34; pat_mem[2] = 8'h56; pat_mem[3] = 8'h78;
        gold_i[0] = 3'd0; gold_i[1] = 3'd0;
        gold_d[0] = 8'h46; gold_d[1] = 8'hCE;
        do_run(1'b0, 1'b0, 1'b0);

        // Injected mismatch on vector 1, plus a start pulse while busy.
        gold_d[1] = 8'hCF;
        do_run(1'b0, 1'b1, 1'b0);

        // Restart straight from DONE after a failing run.
        gold_d[1] = 8'hCE;
        do_run(1'b0, 1'b0, 1'b0);

        // Saturation: three mismatching vectors on top of a near-full count.
        for (int v = 0; v < 3; v++) gold_d[v] = good_f(v) ^ 8'h5A;
        do_run(1'b1, 1'b0, 1'b0);

        // Reset during the first CHECK of a run.
        do_run(1'b1, 1'b0, 1'b1);

        for (int r = 0; r < 20; r++) begin
            randomize_vectors(30);
            do_run(1'b0, (r % 3) == 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fu_vector_sequencer.md
Name: fu_vector_sequencer

Overview:
- Synthesizable self-check engine for the 8-bit Functional_Unit.
- Fetches operand pairs from a pattern memory, and instruction plus expected result from a golden memory.
- Drives the FU inputs, waits a settle window, then compares F against the expected result.
- Counts mismatches and reports per-vector errors and a final pass/fail. Used for on-chip BIST of the FU datapath.

Parameters:
- DATA_W, 8, operand/result width
- INSTR_W, 3, FU instruction width
- ADDR_W, 10, pattern memory address width (golden memory uses ADDR_W-1)
- NUM_VEC, 124, vectors per run; must be >= 1 and <= 2^(ADDR_W-1)
- SETTLE, 1, cycles the FU inputs are held before comparison; must be >= 1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin run; sampled only in IDLE or DONE
- pat_addr  out  ADDR_W  pattern memory address; even = A, odd = B
- pat_data  in  DATA_W  pattern read data, valid the cycle after pat_addr
- gold_addr  out  ADDR_W-1  golden/instruction memory address (= vector index)
- gold_data  in  DATA_W  expected F, valid the cycle after gold_addr
- gold_instr  in  INSTR_W  instruction, valid the cycle after gold_addr
- fu_a, fu_b  out  DATA_W  registered FU operands
- fu_instr  out  INSTR_W  registered FU instruction
- fu_f  in  DATA_W  FU combinational result
- busy  out  1  run in progress
- done  out  1  run complete, held until restart or reset
- pass  out  1  valid while done; 1 iff error_count == 0
- error_count  out  16  mismatch count, saturates at 16'hFFFF
- err_pulse  out  1  one-cycle strobe on a mismatch
- err_index  out  ADDR_W-1  vector index of the last mismatch
- err_got, err_exp  out  DATA_W  fu_f and expected value of the last mismatch

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including pat_addr, gold_addr, fu_*, error_count and the err_* fields.
- States: IDLE, RD_A, RD_B, CAP_B, APPLY, CHECK, DONE.
- IDLE/DONE with start=1: clear error_count, err_*, done and pass; idx <= 0; go to RD_A. With start=0, hold state.
- RD_A: pat_addr = 2*idx; gold_addr = idx.
- RD_B: pat_addr = 2*idx+1. Capture pat_data into an A holding register, and gold_data/gold_instr into expected/instr holding registers.
- CAP_B: capture pat_data as B. Load fu_a, fu_b and fu_instr together on this edge, so they are never partially updated. Load the settle counter with SETTLE.
- APPLY: decrement the counter each cycle; leave when it reaches 0, i.e. exactly SETTLE cycles. fu_* stay stable.
- CHECK:
  - Compare fu_f with expected.
  - On mismatch: err_pulse=1 for this single cycle; err_index=idx, err_got=fu_f, err_exp=expected; error_count increments, saturating.
  - Exit: if idx == NUM_VEC-1, go to DONE; else idx++ and go to RD_A.
- Cycle count:
  - Per vector: 4+SETTLE cycles.
  - Start is sampled at edge 0; done rises (1 + (4+SETTLE)*NUM_VEC) cycles after that edge.
- DONE: done=1, busy=0, pass registered. fu_* keep the last vector's values.
- busy = 1 in every state except IDLE and DONE. start is ignored while busy.
- err_* fields hold their last values until the next start or reset.
- X on fu_f is treated as a mismatch, since the comparison is not equal.
- Reset mid-run: immediate return to IDLE with all outputs cleared; no partial results are retained.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-CHECK.
  - Response: immediately busy=0, done=0, fu_a=fu_b=0, error_count=0, state IDLE.
- Two-vector run:
  - Stimulus: NUM_VEC=2, SETTLE=1, pattern {12,34,56,78}, golden {46,CE}, instr {000,000}, bench FU = adder.
  - Response: pat_addr sequence 0,1,2,3. fu_a=12, fu_b=34 during the first APPLY. done at cycle 11, pass=1, error_count=0.
- Injected mismatch:
  - Stimulus: same as the two-vector run, but golden[1]=CF.
  - Response: exactly one err_pulse, with err_index=1, err_got=CE, err_exp=CF. error_count=1, pass=0.
- Start handling:
  - Stimulus: pulse start at cycle 4; then pulse start in DONE after a failing run.
  - Response: the cycle-4 pulse is ignored, and done timing is unchanged. The restart clears error_count to 0 and reruns all vectors.
- Reset and settle variants:
  - Stimulus: rst_n low during vector 1 of a 124-vector run, then release and start.
  - Response: the clean run gives done at cycle 621 with pass=1. With SETTLE=3, done is at 1+7*124=869.
- Saturation:
  - Stimulus: force error_count to FFFE, then apply 3 mismatching vectors.
  - Response: error_count=FFFF, and err_pulse still fires on each of the 3 vectors.
